// File: rtl/axi_stream_packet_source.sv
// AXI4-Stream packet generator: incrementing-data packets with tkeep/tlast framing and inter-packet gaps.
// Optional statistics counters are enabled by defining AXIS_SRC_STATS_EN.
module axi_stream_packet_source #(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 1,
  parameter int ID_WIDTH   = 1,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LEN_WIDTH-1:0]    cfg_bytes,
  input  logic [7:0]              cfg_pkts,
  input  logic [7:0]              cfg_gap,
  input  logic [DATA_WIDTH-1:0]   cfg_seed,
  input  logic [USER_WIDTH-1:0]   cfg_user,
  input  logic [DEST_WIDTH-1:0]   cfg_dest,
  input  logic [ID_WIDTH-1:0]     cfg_id,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [DATA_WIDTH/8-1:0] m_tstrb,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic [USER_WIDTH-1:0]   m_tuser,
  output logic [DEST_WIDTH-1:0]   m_tdest,
  output logic [ID_WIDTH-1:0]     m_tid,
  output logic                    busy,
  output logic                    done,
  output logic                    err_cfg,
  output logic [31:0]             stat_beats,
  output logic [31:0]             stat_stalls
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_SEND | presenting beats (tvalid=1)
  // S_GAP  | idle cycles between packets
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [LEN_WIDTH-1:0] BYTES_L = LEN_WIDTH'(BYTES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_t;

  state_t                  r_state, w_state_nxt;
  logic [1:0]              r_rst_sync;
  logic                    w_rst;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [LEN_WIDTH-1:0]    r_bytes_left, r_cfg_bytes;
  logic [7:0]              r_pkts_left, r_cfg_gap, r_gap_cnt;
  logic [ID_WIDTH-1:0]     r_tid;
  logic [USER_WIDTH-1:0]   r_user;
  logic [DEST_WIDTH-1:0]   r_dest;
  logic [BYTES-1:0]        r_keep;
  logic                    r_last, r_abort, r_done, r_err;
  logic                    w_cfg_ok, w_accept, w_reject, w_hs, w_abort_any, w_pkt_end, w_final, w_done_nxt;
  logic [LEN_WIDTH-1:0]    w_bytes_rem;

  // Bytes still to send (including the current beat) map directly onto keep bits.
  function automatic logic [BYTES-1:0] keep_for(input logic [LEN_WIDTH-1:0] rem);
    logic [BYTES-1:0] k;
    for (int i = 0; i < BYTES; i++) k[i] = (rem > LEN_WIDTH'(i));
    return k;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rst_sync <= 2'b11;
    else     r_rst_sync <= {r_rst_sync[0], 1'b0};
  end
  assign w_rst = r_rst_sync[1];

  assign w_cfg_ok    = (cfg_bytes != '0) && (cfg_pkts != 8'd0);
  assign w_accept    = (r_state == S_IDLE) && start && w_cfg_ok;
  assign w_reject    = (r_state == S_IDLE) && start && !w_cfg_ok;
  assign w_hs        = (r_state == S_SEND) && m_tready;
  assign w_abort_any = r_abort || abort;
  assign w_pkt_end   = w_hs && r_last;
  assign w_final     = w_pkt_end && ((r_pkts_left == 8'd0) || w_abort_any);
  assign w_bytes_rem = r_bytes_left - BYTES_L;
  assign w_done_nxt  = w_final || ((r_state == S_GAP) && w_abort_any);

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_final)                            w_state_nxt = S_IDLE;
        else if (w_pkt_end && r_cfg_gap != 8'd0) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (w_abort_any)              w_state_nxt = S_IDLE;
        else if (r_gap_cnt == 8'd0)   w_state_nxt = S_SEND;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    m_tvalid = (r_state == S_SEND);
    busy     = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_data <= '0;  r_bytes_left <= '0; r_cfg_bytes <= '0; r_pkts_left <= '0;
      r_cfg_gap <= '0; r_gap_cnt <= '0; r_tid <= '0; r_user <= '0; r_dest <= '0;
      r_keep <= '0; r_last <= 1'b0; r_abort <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      r_err  <= w_reject;
      if (w_accept) begin
        r_data       <= cfg_seed;
        r_bytes_left <= cfg_bytes;
        r_cfg_bytes  <= cfg_bytes;
        r_pkts_left  <= cfg_pkts - 8'd1;
        r_cfg_gap    <= cfg_gap;
        r_tid        <= cfg_id;
        r_user       <= cfg_user;
        r_dest       <= cfg_dest;
        r_last       <= (cfg_bytes <= BYTES_L);
        r_keep       <= keep_for(cfg_bytes);
        r_abort      <= 1'b0;
      end else begin
        if (busy && abort) r_abort <= 1'b1;
        if (w_hs) begin
          r_data <= r_data + DATA_WIDTH'(1);
          if (r_last) begin
            // reload framing for the next packet; unused if this was the final one
            r_bytes_left <= r_cfg_bytes;
            r_last       <= (r_cfg_bytes <= BYTES_L);
            r_keep       <= keep_for(r_cfg_bytes);
            r_tid        <= r_tid + ID_WIDTH'(1);
            r_pkts_left  <= r_pkts_left - 8'd1;
            r_gap_cnt    <= r_cfg_gap - 8'd1;
          end else begin
            r_bytes_left <= w_bytes_rem;
            r_last       <= (w_bytes_rem <= BYTES_L);
            r_keep       <= keep_for(w_bytes_rem);
          end
        end
        if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt - 8'd1;
      end
    end
  end

  assign m_tdata = r_data;
  assign m_tlast = r_last && (r_state == S_SEND);
  assign m_tkeep = r_keep;
  assign m_tstrb = r_keep;
  assign m_tuser = r_user;
  assign m_tdest = r_dest;
  assign m_tid   = r_tid;
  assign done    = r_done;
  assign err_cfg = r_err;

`ifdef AXIS_SRC_STATS_EN
  logic [31:0] r_stat_beats, r_stat_stalls;

  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_stat_beats  <= '0;
      r_stat_stalls <= '0;
    end else if (w_accept) begin
      r_stat_beats  <= '0;
      r_stat_stalls <= '0;
    end else begin
      if (w_hs && (r_stat_beats != '1)) r_stat_beats <= r_stat_beats + 32'd1;
      if (m_tvalid && !m_tready && (r_stat_stalls != '1)) r_stat_stalls <= r_stat_stalls + 32'd1;
    end
  end

  assign stat_beats  = r_stat_beats;
  assign stat_stalls = r_stat_stalls;
`else
  assign stat_beats  = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_axi_stream_packet_source.sv
// Randomized self-checking bench for axi_stream_packet_source against a packet-level reference model.
// Statistics expectations follow AXIS_SRC_STATS_EN when it is defined for the build.
module tb_axi_stream_packet_source;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic [3:0]  strb;
    logic        last;
    logic [3:0]  tid;
    logic [1:0]  user;
    logic [2:0]  dest;
  } beat_t;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, m_tready = 1'b1;
  logic [15:0] cfg_bytes = '0;
  logic [7:0]  cfg_pkts = '0, cfg_gap = '0;
  logic [31:0] cfg_seed = '0;
  logic [1:0]  cfg_user = '0;
  logic [2:0]  cfg_dest = '0;
  logic [3:0]  cfg_id = '0;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast, busy, done, err_cfg;
  logic [3:0]  m_tstrb, m_tkeep, m_tid;
  logic [1:0]  m_tuser;
  logic [2:0]  m_tdest;
  logic [31:0] stat_beats, stat_stalls;

  axi_stream_packet_source #(
    .DATA_WIDTH(32), .USER_WIDTH(2), .DEST_WIDTH(3), .ID_WIDTH(4), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_bytes(cfg_bytes), .cfg_pkts(cfg_pkts), .cfg_gap(cfg_gap), .cfg_seed(cfg_seed),
    .cfg_user(cfg_user), .cfg_dest(cfg_dest), .cfg_id(cfg_id),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tdest(m_tdest), .m_tid(m_tid),
    .busy(busy), .done(done), .err_cfg(err_cfg), .stat_beats(stat_beats), .stat_stalls(stat_stalls)
  );

  always #5 clk = ~clk;

  int    checks = 0, errors = 0;
  beat_t got_q[$], exp_q[$];
  bit    vtrace[$];
  int    stalls_seen, viol, err_cnt, done_lat;
  bit    first_valid, first_busy, busy_at_done, valid_at_done, done_after, timed_out;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected beats for a command of 'pkts' packets of 'bytes' bytes each.
  task automatic model_build(input int bytes, input int pkts, input logic [31:0] seed,
                             input logic [3:0] id, input logic [1:0] user, input logic [2:0] dest);
    beat_t b;
    int nb, rem, idx;
    exp_q.delete();
    nb  = (bytes + 3) / 4;
    idx = 0;
    for (int p = 0; p < pkts; p++) begin
      for (int k = 0; k < nb; k++) begin
        rem    = bytes - 4 * k;
        b.data = seed + 32'(idx);
        b.keep = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
        b.strb = b.keep;
        b.last = (k == nb - 1);
        b.tid  = id + 4'(p);
        b.user = user;
        b.dest = dest;
        exp_q.push_back(b);
        idx++;
      end
    end
  endtask

  // Packets actually sent when abort is raised once 'abort_k' beats have been accepted.
  function automatic int exp_pkts(input int bytes, input int pkts, input int gap, input int abort_k);
    int nb;
    nb = (bytes + 3) / 4;
    if (abort_k < 0 || abort_k >= nb * pkts) return pkts;
    if (abort_k > 0 && (abort_k % nb) == 0 && gap > 0) return abort_k / nb;
    return abort_k / nb + 1;
  endfunction

  function automatic void gap_runs(input int gap, output int nruns, output int nbad);
    int run;
    bit seen_one;
    nruns = 0; nbad = 0; run = 0; seen_one = 0;
    foreach (vtrace[i]) begin
      if (vtrace[i]) begin
        if (seen_one && run > 0) begin
          nruns++;
          if (run != gap) nbad++;
        end
        seen_one = 1;
        run = 0;
      end else run++;
    end
  endfunction

  // Issues start with the current cfg_* and records the stream until done or budget expiry.
  task automatic run_cmd(input int ready_pct, input int stall_k, input int stall_len,
                         input int abort_k, input int busy_start_cyc, input int budget);
    int nacc, cyc, stall_left, last_acc;
    bit prev_stall, aborted, seen_done;
    beat_t cur, prev_b;
    got_q.delete(); vtrace.delete();
    stalls_seen = 0; viol = 0; err_cnt = 0; done_lat = -1;
    nacc = 0; cyc = 0; stall_left = stall_len; last_acc = -1;
    prev_stall = 0; aborted = 0; seen_done = 0; prev_b = '0;
    @(posedge clk); #1 start = 1'b1; m_tready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    first_valid = m_tvalid;
    first_busy  = busy;
    while (!seen_done && cyc < budget) begin
      if (stall_k >= 0 && nacc == stall_k && stall_left > 0) begin
        m_tready = 1'b0;
        stall_left--;
      end else m_tready = ($urandom_range(99) < ready_pct);
      abort = (abort_k >= 0 && !aborted && nacc == abort_k);
      if (abort) aborted = 1;
      start = (cyc == busy_start_cyc);
      if (start) cfg_bytes = 16'd0;
      cur = {m_tdata, m_tkeep, m_tstrb, m_tlast, m_tid, m_tuser, m_tdest};
      if (prev_stall && (!m_tvalid || cur !== prev_b)) viol++;
      prev_stall = m_tvalid && !m_tready;
      prev_b = cur;
      if (m_tvalid && !m_tready) stalls_seen++;
      if (err_cfg) err_cnt++;
      if (done) begin
        seen_done = 1;
        busy_at_done = busy;
        valid_at_done = m_tvalid;
        done_lat = cyc - last_acc;
      end else vtrace.push_back(m_tvalid);
      if (m_tvalid && m_tready) begin
        got_q.push_back(cur);
        nacc++;
        last_acc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; abort = 1'b0; m_tready = 1'b1;
    timed_out = !seen_done;
    done_after = done;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_tdata, m_tvalid, m_tlast, m_tstrb, m_tkeep, m_tuser, m_tdest, m_tid, busy, done, err_cfg,
         stat_beats, stat_stalls} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: tvalid=%b tdata=%h busy=%b required all zero", m_tvalid, m_tdata, busy);
    end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({m_tvalid, busy, done, err_cfg} !== 4'b0) begin
      errors++;
      $display("FAIL reset_release_idle: valid/busy/done/err=%b required 0000", {m_tvalid, busy, done, err_cfg});
    end
  endtask

  task automatic test_basic();
    cfg_bytes = 16'd10; cfg_pkts = 8'd1; cfg_gap = 8'd0; cfg_seed = 32'h100;
    cfg_id = 4'd2; cfg_user = 2'd1; cfg_dest = 3'd6;
    model_build(10, 1, 32'h100, 4'd2, 2'd1, 3'd6);
    run_cmd(100, -1, 0, -1, -1, 50);
    checks++;
    if (timed_out) begin errors++; $display("FAIL basic_timeout: no done within budget"); end
    checks++;
    if ({first_valid, first_busy} !== 2'b11) begin
      errors++; $display("FAIL basic_latency: valid/busy after start=%b required 11", {first_valid, first_busy});
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL basic_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_lat !== 1 || {busy_at_done, valid_at_done, done_after} !== 3'b000) begin
      errors++;
      $display("FAIL basic_done: latency=%0d busy/valid/next_done=%b required 1 and 000",
               done_lat, {busy_at_done, valid_at_done, done_after});
    end
  endtask

  task automatic test_backpressure();
    cfg_bytes = 16'd10; cfg_pkts = 8'd1; cfg_gap = 8'd0; cfg_seed = 32'h100;
    cfg_id = 4'd0; cfg_user = 2'd0; cfg_dest = 3'd0;
    model_build(10, 1, 32'h100, 4'd0, 2'd0, 3'd0);
    run_cmd(100, 1, 4, -1, -1, 50);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL bp_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (viol !== 0 || stalls_seen !== 4) begin
      errors++; $display("FAIL bp_stability: violations=%0d stalls=%0d required 0 and 4", viol, stalls_seen);
    end
`ifdef AXIS_SRC_STATS_EN
    checks++;
    if (stat_beats !== 32'd3 || stat_stalls !== 32'd4) begin
      errors++; $display("FAIL bp_stats: beats=%0d stalls=%0d required 3 and 4", stat_beats, stat_stalls);
    end
`else
    checks++;
    if ({stat_beats, stat_stalls} !== 64'd0) begin
      errors++; $display("FAIL bp_stats_off: beats=%0d stalls=%0d required 0", stat_beats, stat_stalls);
    end
`endif
  endtask

  task automatic test_gap();
    int nruns, nbad;
    cfg_bytes = 16'd4; cfg_pkts = 8'd3; cfg_gap = 8'd2; cfg_seed = 32'h100;
    cfg_id = 4'd5; cfg_user = 2'd2; cfg_dest = 3'd1;
    model_build(4, 3, 32'h100, 4'd5, 2'd2, 3'd1);
    run_cmd(100, -1, 0, -1, -1, 60);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL gap_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL gap_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    gap_runs(2, nruns, nbad);
    checks++;
    if (nruns !== 2 || nbad !== 0) begin
      errors++; $display("FAIL gap_idle: runs=%0d wrong_len=%0d required 2 and 0", nruns, nbad);
    end
  endtask

  task automatic test_back_to_back();
    int nruns, nbad;
    cfg_bytes = 16'd8; cfg_pkts = 8'd2; cfg_gap = 8'd0; cfg_seed = 32'hFFFF_FFFE;
    cfg_id = 4'd15; cfg_user = 2'd3; cfg_dest = 3'd7;
    model_build(8, 2, 32'hFFFF_FFFE, 4'd15, 2'd3, 3'd7);
    run_cmd(100, -1, 0, -1, -1, 60);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    gap_runs(0, nruns, nbad);
    checks++;
    if (nruns !== 0 || vtrace.size() !== 4 || done_lat !== 1) begin
      errors++;
      $display("FAIL b2b_timing: idle_runs=%0d valid_cycles=%0d done_lat=%0d required 0, 4, 1",
               nruns, vtrace.size(), done_lat);
    end
  endtask

  task automatic test_err_cfg();
    for (int t = 0; t < 2; t++) begin
      cfg_bytes = (t == 0) ? 16'd0 : 16'd12;
      cfg_pkts  = (t == 0) ? 8'd3  : 8'd0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      checks++;
      if ({err_cfg, m_tvalid, busy} !== 3'b100) begin
        errors++; $display("FAIL err_cfg_pulse[%0d]: err/valid/busy=%b required 100", t, {err_cfg, m_tvalid, busy});
      end
      @(posedge clk); #1;
      checks++;
      if ({err_cfg, m_tvalid, busy} !== 3'b000) begin
        errors++; $display("FAIL err_cfg_clear[%0d]: err/valid/busy=%b required 000", t, {err_cfg, m_tvalid, busy});
      end
    end
  endtask

  task automatic test_busy_start();
    cfg_bytes = 16'd20; cfg_pkts = 8'd2; cfg_gap = 8'd1; cfg_seed = 32'hABCD_0000;
    cfg_id = 4'd9; cfg_user = 2'd1; cfg_dest = 3'd2;
    model_build(20, 2, 32'hABCD_0000, 4'd9, 2'd1, 3'd2);
    run_cmd(100, -1, 0, -1, 3, 80);
    checks++;
    if (err_cnt !== 0 || got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL busy_start: err_pulses=%0d beats=%0d required 0 and %0d", err_cnt, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL busy_start_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_abort();
    cfg_bytes = 16'd12; cfg_pkts = 8'd3; cfg_gap = 8'd1; cfg_seed = 32'h40;
    cfg_id = 4'd1; cfg_user = 2'd0; cfg_dest = 3'd4;
    model_build(12, exp_pkts(12, 3, 1, 1), 32'h40, 4'd1, 2'd0, 3'd4);
    run_cmd(100, -1, 0, 1, -1, 80);
    checks++;
    if (timed_out || got_q.size() !== 3) begin
      errors++; $display("FAIL abort_count: timeout=%b beats=%0d required 0 and 3", timed_out, got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL abort_beat[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_lat !== 1 || {busy_at_done, valid_at_done} !== 2'b00) begin
      errors++; $display("FAIL abort_done: latency=%0d busy/valid=%b required 1 and 00", done_lat, {busy_at_done, valid_at_done});
    end
  endtask

  task automatic test_random();
    int bytes, pkts, gap, rdy, ak, np, nruns, nbad;
    logic [31:0] seed;
    logic [3:0] id;
    logic [1:0] user;
    logic [2:0] dest;
    for (int it = 0; it < 16; it++) begin
      bytes = $urandom_range(1, 40); pkts = $urandom_range(1, 4); gap = $urandom_range(0, 3);
      rdy = $urandom_range(50, 100); seed = $urandom; id = 4'($urandom); user = 2'($urandom); dest = 3'($urandom);
      ak = ($urandom_range(2) == 0) ? $urandom_range(0, ((bytes + 3) / 4) * pkts - 1) : -1;
      cfg_bytes = 16'(bytes); cfg_pkts = 8'(pkts); cfg_gap = 8'(gap); cfg_seed = seed;
      cfg_id = id; cfg_user = user; cfg_dest = dest;
      np = exp_pkts(bytes, pkts, gap, ak);
      model_build(bytes, np, seed, id, user, dest);
      run_cmd(rdy, -1, 0, ak, -1, 2000);
      checks++;
      if (timed_out || got_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL rand[%0d]_count: timeout=%b beats=%0d required %0d (bytes=%0d pkts=%0d gap=%0d abort_k=%0d)",
                 it, timed_out, got_q.size(), exp_q.size(), bytes, pkts, gap, ak);
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand[%0d]_beat[%0d]: got %h required %h", it, i, got_q[i], exp_q[i]);
        end
      end
      gap_runs(gap, nruns, nbad);
      checks++;
      if (viol !== 0 || nbad !== 0 || nruns !== ((gap > 0) ? np - 1 : 0)) begin
        errors++;
        $display("FAIL rand[%0d]_timing: stall_violations=%0d idle_runs=%0d wrong_len=%0d required 0, %0d, 0",
                 it, viol, nruns, nbad, (gap > 0) ? np - 1 : 0);
      end
`ifdef AXIS_SRC_STATS_EN
      checks++;
      if (stat_beats !== 32'(exp_q.size()) || stat_stalls !== 32'(stalls_seen)) begin
        errors++;
        $display("FAIL rand[%0d]_stats: beats=%0d stalls=%0d required %0d and %0d",
                 it, stat_beats, stat_stalls, exp_q.size(), stalls_seen);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    cfg_bytes = 16'd40; cfg_pkts = 8'd2; cfg_gap = 8'd0; cfg_seed = 32'h5555_0000;
    cfg_id = 4'd3; cfg_user = 2'd3; cfg_dest = 3'd5;
    m_tready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({m_tdata, m_tvalid, m_tlast, m_tstrb, m_tkeep, m_tuser, m_tdest, m_tid, busy, done, err_cfg,
         stat_beats, stat_stalls} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: tvalid=%b tdata=%h tid=%h busy=%b required all zero", m_tvalid, m_tdata, m_tid, busy);
    end
    @(posedge clk); #1 rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done || m_tvalid) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++; $display("FAIL reset_mid_after: cycles with done or tvalid=%0d required 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_gap();
    test_back_to_back();
    test_err_cfg();
    test_busy_start();
    test_abort();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
